multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS datapath in CPUTOP.
- Sequences each instruction through the IF/ID/EXE/MEM/WB states.
- Decodes op/func from the instruction register and drives every datapath enable and mux select: PCWre, IRWre, RegWre, mRD, mWR, and the related selects.
- Sits directly upstream of the datapath registers (IR, A/B, result, DB) and consumes the ALU zero flag.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- RA_REG, 5'd31, link register written by jal; informational only, because RegDst=00 selects it in the datapath.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag; valid in EXE.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read; constant 1.
- ExtSel  out  1  0 = zero-extend imm16, 1 = sign-extend.
- ALUSrcA  out  1  1 = shamt, 0 = A.
- ALUSrcB  out  1  1 = ext imm, 0 = B.
- ALUOp  out  4  0000 ADD, 0001 SUB, 0010 SLL (B<<A), 0011 OR, 0100 AND, 0101 SLT signed.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- RegWre  out  1  register file write enable.
- WrRegDSrc  out  1  0 = PC+4, 1 = DB.
- DBDataSrc  out  1  0 = ALU result, 1 = data memory.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(sext imm<<2), 10 = rs, 11 = {PC[31:28], addr26, 2'b00}.
- state  out  3  current state, for debug.
- halted  out  1  FSM is in HALT.

Behaviour:
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- All outputs are combinational from the registered state plus op/func. op/func are stable from ID onward because IR loads only in IF.
- Reset (RST=1, asynchronous): state=IF; PCWre, IRWre, RegWre, mRD and mWR are forced to 0; halted=0; every other output is 0 except InsMemRW=1.
- First rising edge after RST deasserts: FSM is in IF. RST asserted mid-instruction (for example in MEM) aborts immediately with no write.
- IF: IRWre=1. Next state ID.
- Instruction sequences (PCWre=1 only in the final state of each instruction; that final state always returns to IF):
  - R-arith (add/sub/and/or/slt/sll, op=0): IF-ID-EXE-WB. WB: RegDst=10, RegWre=1, WrRegDSrc=1, DBDataSrc=0. 4 cycles.
  - I-arith (addi 001000, ori 001101, slti 001010): IF-ID-EXE-WB. ALUSrcB=1; RegDst=01. ori has ExtSel=0. 4 cycles.
  - lw (100011): IF-ID-EXE-MEM-WB. EXE uses ADD with ALUSrcB=1. MEM: mRD=1. WB: DBDataSrc=1, RegWre=1, RegDst=01. 5 cycles.
  - sw (101011): IF-ID-EXE-MEM. MEM: mWR=1, PCWre=1. 4 cycles.
  - beq (000100) / bne (000101): IF-ID-EXE. EXE: ALUOp=SUB, PCWre=1.
    - beq: PCSrc=01 if zero=1, else 00.
    - bne: PCSrc=01 if zero=0, else 00.
    - 3 cycles.
  - j (000010): IF-ID. ID: PCSrc=11.
  - jal (000011): IF-ID. ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - jr (op=0, func=001000): IF-ID. ID: PCSrc=10. No register write.
  - HALT_OP: IF-ID-HALT. HALT is held until reset; all enables are 0 and halted=1.
  - Unknown op, or op=0 with an unknown func: executes as a NOP. IF-ID with PCWre=1, PCSrc=00, no writes.
- ALU control per instruction:
  - R-type: func 100000→ADD, 100010→SUB, 100100→AND, 100101→OR, 101010→SLT, 000000→SLL with ALUSrcA=1.
  - addi→ADD, ori→OR, slti→SLT.
- ExtSel=1 everywhere except ori.
- mRD and mWR are never asserted in the same cycle. RegWre is never asserted in IF.

Decomposition:
- Package cpu_defs holds:
  - opcode and func constants;
  - ALUOp codes;
  - state encodings;
  - PCSrc and RegDst encodings.
- Sub-module ctrl_decode is purely combinational. It maps op/func to an instruction class (RARITH, IARITH, LW, SW, BR, JMP, JAL, JR, HALT, NOP) plus the static selects ALUOp, ALUSrcA/B, ExtSel and RegDst.
- multicycle_ctrl holds the state register, the next-state logic, and the gating of enables by state.

Test Plan:
- addi $1,$0,5 (op 001000) → states IF,ID,EXE,WB. WB: RegWre=1, RegDst=01, ALUSrcB=1, ALUOp=0000. PCWre=1 only in WB.
- lw (100011) → 5 states. mRD=1 only in MEM. WB: DBDataSrc=1, RegWre=1. mWR stays 0 throughout.
- beq with zero=1 in EXE → PCSrc=01, PCWre=1. With zero=0 → PCSrc=00. bne → the inverse of both cases.
- jal (000011) → IF,ID only. ID: PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- sll (op 0, func 000000) → ALUSrcA=1, ALUOp=0010. Unknown op 110011 → 2-cycle NOP with no RegWre, mWR or mRD.
- RST=1 asserted mid-MEM of sw → state=000 immediately and mWR=0. halt (111111) → halted=1 and every enable stays 0 for 20 cycles.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funcs,
// ALU operations, FSM states and datapath select codes.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // jal links into $31; the datapath picks it when RegDst selects RD_RA.
    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_SLL = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_SLT = 4'b0101
    } aluOp_e;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_e;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_REG    = 2'b10,
        PC_JUMP   = 2'b11
    } pcSrc_e;

    typedef enum logic [1:0] {
        RD_RA = 2'b00,
        RD_RT = 2'b01,
        RD_RD = 2'b10
    } regDst_e;

    typedef enum logic [3:0] {
        C_RARITH,
        C_IARITH,
        C_LW,
        C_SW,
        C_BR,
        C_JMP,
        C_JAL,
        C_JR,
        C_HALT,
        C_NOP
    } instrClass_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies op/func and produces the
// selects that stay constant for the whole instruction.
module ctrl_decode
    import cpu_defs::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instrClass_e  instrClass,
    output logic         brOnNotZero,
    output logic [3:0]   aluOp,
    output logic         aluSrcA,
    output logic         aluSrcB,
    output logic         extSel,
    output logic [1:0]   regDst
);

    always_comb begin
        instrClass  = C_NOP;
        brOnNotZero = 1'b0;
        aluOp       = ALU_ADD;
        aluSrcA     = 1'b0;
        aluSrcB     = 1'b0;
        extSel      = 1'b1;
        regDst      = RD_RA;

        if (op == HALT_OP) begin
            instrClass = C_HALT;
        end else begin
            case (op)
                OP_RTYPE: begin
                    instrClass = C_RARITH;
                    regDst     = RD_RD;
                    case (func)
                        FN_ADD: aluOp = ALU_ADD;
                        FN_SUB: aluOp = ALU_SUB;
                        FN_AND: aluOp = ALU_AND;
                        FN_OR:  aluOp = ALU_OR;
                        FN_SLT: aluOp = ALU_SLT;
                        FN_SLL: begin
                            aluOp   = ALU_SLL;
                            aluSrcA = 1'b1;
                        end
                        FN_JR: begin
                            instrClass = C_JR;
                            regDst     = RD_RA;
                        end
                        default: begin
                            instrClass = C_NOP;
                            regDst     = RD_RA;
                        end
                    endcase
                end
                OP_ADDI: begin
                    instrClass = C_IARITH;
                    aluSrcB    = 1'b1;
                    regDst     = RD_RT;
                end
                OP_ORI: begin
                    instrClass = C_IARITH;
                    aluOp      = ALU_OR;
                    aluSrcB    = 1'b1;
                    extSel     = 1'b0;
                    regDst     = RD_RT;
                end
                OP_SLTI: begin
                    instrClass = C_IARITH;
                    aluOp      = ALU_SLT;
                    aluSrcB    = 1'b1;
                    regDst     = RD_RT;
                end
                OP_LW: begin
                    instrClass = C_LW;
                    aluSrcB    = 1'b1;
                    regDst     = RD_RT;
                end
                OP_SW: begin
                    instrClass = C_SW;
                    aluSrcB    = 1'b1;
                end
                OP_BEQ: begin
                    instrClass = C_BR;
                    aluOp      = ALU_SUB;
                end
                OP_BNE: begin
                    instrClass  = C_BR;
                    brOnNotZero = 1'b1;
                    aluOp       = ALU_SUB;
                end
                OP_J:    instrClass = C_JMP;
                OP_JAL:  instrClass = C_JAL;
                default: instrClass = C_NOP;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and gates the
// decoder's static selects and the datapath enables by state.
//
//  state | meaning
//  IF    | fetch, IR loads
//  ID    | decode; jumps, jal, jr and NOPs retire here
//  EXE   | ALU operation; branches retire here
//  MEM   | data memory access; sw retires here
//  WB    | register write-back
//  HALT  | parked until reset
module multicycle_ctrl
    import cpu_defs::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic [2:0] state,
    output logic       halted
);

    state_e      curState;
    state_e      nextState;
    instrClass_e iClass;
    logic        brOnNotZero;
    logic [3:0]  decAluOp;
    logic        decAluSrcA;
    logic        decAluSrcB;
    logic        decExtSel;
    logic [1:0]  decRegDst;
    logic        useStatic;

    ctrl_decode #(.HALT_OP(HALT_OP)) uDecode (
        .op          (op),
        .func        (func),
        .instrClass  (iClass),
        .brOnNotZero (brOnNotZero),
        .aluOp       (decAluOp),
        .aluSrcA     (decAluSrcA),
        .aluSrcB     (decAluSrcB),
        .extSel      (decExtSel),
        .regDst      (decRegDst)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) curState <= S_IF;
        else     curState <= nextState;
    end

    assign state = curState;

    // RST also masks the outputs combinationally so nothing is written while it is held.
    always_comb begin
        nextState = curState;
        useStatic = 1'b0;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b1;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        RegDst    = RD_RA;
        RegWre    = 1'b0;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PC_NEXT;
        halted    = 1'b0;

        if (!RST) begin
            case (curState)
                S_IF: begin
                    IRWre     = 1'b1;
                    nextState = S_ID;
                end
                S_ID: begin
                    useStatic = 1'b1;
                    case (iClass)
                        C_JMP: begin
                            PCWre     = 1'b1;
                            PCSrc     = PC_JUMP;
                            nextState = S_IF;
                        end
                        C_JAL: begin
                            PCWre     = 1'b1;
                            PCSrc     = PC_JUMP;
                            RegWre    = 1'b1;
                            nextState = S_IF;
                        end
                        C_JR: begin
                            PCWre     = 1'b1;
                            PCSrc     = PC_REG;
                            nextState = S_IF;
                        end
                        C_NOP: begin
                            PCWre     = 1'b1;
                            nextState = S_IF;
                        end
                        C_HALT:  nextState = S_HALT;
                        default: nextState = S_EXE;
                    endcase
                end
                S_EXE: begin
                    useStatic = 1'b1;
                    case (iClass)
                        C_BR: begin
                            PCWre     = 1'b1;
                            PCSrc     = (zero ^ brOnNotZero) ? PC_BRANCH : PC_NEXT;
                            nextState = S_IF;
                        end
                        C_LW, C_SW: nextState = S_MEM;
                        default:    nextState = S_WB;
                    endcase
                end
                S_MEM: begin
                    useStatic = 1'b1;
                    case (iClass)
                        C_LW: begin
                            mRD       = 1'b1;
                            nextState = S_WB;
                        end
                        C_SW: begin
                            mWR       = 1'b1;
                            PCWre     = 1'b1;
                            nextState = S_IF;
                        end
                        default: nextState = S_IF;
                    endcase
                end
                S_WB: begin
                    useStatic = 1'b1;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = (iClass == C_LW);
                    PCWre     = 1'b1;
                    nextState = S_IF;
                end
                S_HALT: begin
                    halted    = 1'b1;
                    nextState = S_HALT;
                end
                default: nextState = S_IF;
            endcase

            if (useStatic) begin
                ExtSel  = decExtSel;
                ALUSrcA = decAluSrcA;
                ALUSrcB = decAluSrcB;
                ALUOp   = decAluOp;
                RegDst  = decRegDst;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction table, randomized
// instruction stream against a per-instruction reference model, and reset/halt corners.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] RegDst;
    logic       RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] state;
    logic       halted;

    int nChecks = 0;
    int nFail   = 0;

    multicycle_ctrl dut (
        .CLK(CLK), .RST(RST), .op(op), .func(func), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state), .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic       pcWre, irWre, insMemRw, extSel, aluSrcA, aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] regDst;
        logic       regWre, wrRegDSrc, dbDataSrc, mRd, mWr;
        logic [1:0] pcSrc;
        logic       halted;
    } snap_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        int         cycles;
        logic [1:0] pcSrc;
        string      name;
    } vec_t;

    function automatic snap_t sample();
        snap_t s;
        s.st = state; s.pcWre = PCWre; s.irWre = IRWre; s.insMemRw = InsMemRW;
        s.extSel = ExtSel; s.aluSrcA = ALUSrcA; s.aluSrcB = ALUSrcB; s.aluOp = ALUOp;
        s.regDst = RegDst; s.regWre = RegWre; s.wrRegDSrc = WrRegDSrc;
        s.dbDataSrc = DBDataSrc; s.mRd = mRD; s.mWr = mWR; s.pcSrc = PCSrc;
        s.halted = halted;
        return s;
    endfunction

    function automatic snap_t resetVec();
        snap_t e = '0;
        e.insMemRw = 1'b1;
        return e;
    endfunction

    // Expected outputs for cycle 'step' of one instruction, straight from the instruction rules.
    function automatic snap_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int step);
        snap_t e = '0;
        bit isR, isJr, isI, isLw, isSw, isBeq, isBne, isJ, isJal, isHalt, last;
        int len;
        e.insMemRw = 1'b1;
        isR    = (o == 6'h00) && (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00});
        isJr   = (o == 6'h00) && (f == 6'h08);
        isI    = o inside {6'h08, 6'h0d, 6'h0a};
        isLw   = (o == 6'h23);
        isSw   = (o == 6'h2b);
        isBeq  = (o == 6'h04);
        isBne  = (o == 6'h05);
        isJ    = (o == 6'h02);
        isJal  = (o == 6'h03);
        isHalt = (o == 6'h3f);
        len = (isR || isI) ? 4 : isLw ? 5 : isSw ? 4 : (isBeq || isBne) ? 3 : 2;
        if (isHalt && step >= 2) begin
            e.st = 3'b111;
            e.halted = 1'b1;
            return e;
        end
        if (step == 0) begin
            e.irWre = 1'b1;
            return e;
        end
        e.extSel = (o != 6'h0d);
        if (isR) begin
            case (f)
                6'h20: e.aluOp = 4'd0;
                6'h22: e.aluOp = 4'd1;
                6'h24: e.aluOp = 4'd4;
                6'h25: e.aluOp = 4'd3;
                6'h2a: e.aluOp = 4'd5;
                default: e.aluOp = 4'd2;
            endcase
        end else if (o == 6'h0d) e.aluOp = 4'd3;
        else if (o == 6'h0a) e.aluOp = 4'd5;
        else if (isBeq || isBne) e.aluOp = 4'd1;
        e.aluSrcA = isR && (f == 6'h00);
        e.aluSrcB = isI || isLw || isSw;
        e.regDst  = isR ? 2'b10 : (isI || isLw) ? 2'b01 : 2'b00;
        last = !isHalt && (step == len - 1);
        e.pcWre = last;
        case (step)
            1: e.st = 3'b001;
            2: e.st = 3'b010;
            3: e.st = (isLw || isSw) ? 3'b011 : 3'b100;
            default: e.st = 3'b100;
        endcase
        if (step == 1 && (isJ || isJal)) e.pcSrc = 2'b11;
        if (step == 1 && isJr) e.pcSrc = 2'b10;
        if (step == 1 && isJal) e.regWre = 1'b1;
        if (step == 2 && ((isBeq && z) || (isBne && !z))) e.pcSrc = 2'b01;
        if (step == 3 && isLw) e.mRd = 1'b1;
        if (step == 3 && isSw) e.mWr = 1'b1;
        if ((step == 3 && (isR || isI)) || (step == 4 && isLw)) begin
            e.regWre = 1'b1;
            e.wrRegDSrc = 1'b1;
            e.dbDataSrc = isLw;
        end
        return e;
    endfunction

    task automatic check(input string name, input int step, input snap_t a, input snap_t e);
        nChecks++;
        if (a !== e) begin
            nFail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, a, e);
        end
    endtask

    task automatic checkVal(input string name, input int a, input int e);
        nChecks++;
        if (a != e) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // Enter at posedge+1 with the DUT in IF; return at posedge+1 back in IF.
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input string name, output int cycles, output logic [1:0] lastPc);
        snap_t e, a;
        int step = 0;
        bit done = 0;
        lastPc = 2'b00;
        op = o; func = f; zero = z;
        #1;
        while (!done && step < 8) begin
            e = model(o, f, z, step);
            a = sample();
            check(name, step, a, e);
            if (e.pcWre) begin
                done = 1;
                lastPc = a.pcSrc;
            end
            @(posedge CLK); #1;
            step++;
        end
        cycles = step;
    endtask

    vec_t tbl[20];
    logic [5:0] opPool[12];
    logic [5:0] fnPool[8];

    initial begin
        int cyc;
        logic [1:0] pc;
        snap_t a;

        tbl[0]  = '{6'h08, 6'h00, 1'b0, 4, 2'b00, "addi"};
        tbl[1]  = '{6'h0d, 6'h11, 1'b1, 4, 2'b00, "ori"};
        tbl[2]  = '{6'h0a, 6'h00, 1'b0, 4, 2'b00, "slti"};
        tbl[3]  = '{6'h00, 6'h20, 1'b0, 4, 2'b00, "add"};
        tbl[4]  = '{6'h00, 6'h22, 1'b1, 4, 2'b00, "sub"};
        tbl[5]  = '{6'h00, 6'h24, 1'b0, 4, 2'b00, "and"};
        tbl[6]  = '{6'h00, 6'h25, 1'b0, 4, 2'b00, "or"};
        tbl[7]  = '{6'h00, 6'h2a, 1'b0, 4, 2'b00, "slt"};
        tbl[8]  = '{6'h00, 6'h00, 1'b0, 4, 2'b00, "sll"};
        tbl[9]  = '{6'h23, 6'h00, 1'b0, 5, 2'b00, "lw"};
        tbl[10] = '{6'h2b, 6'h00, 1'b0, 4, 2'b00, "sw"};
        tbl[11] = '{6'h04, 6'h00, 1'b1, 3, 2'b01, "beq_taken"};
        tbl[12] = '{6'h04, 6'h00, 1'b0, 3, 2'b00, "beq_not"};
        tbl[13] = '{6'h05, 6'h00, 1'b1, 3, 2'b00, "bne_not"};
        tbl[14] = '{6'h05, 6'h00, 1'b0, 3, 2'b01, "bne_taken"};
        tbl[15] = '{6'h02, 6'h00, 1'b0, 2, 2'b11, "j"};
        tbl[16] = '{6'h03, 6'h00, 1'b0, 2, 2'b11, "jal"};
        tbl[17] = '{6'h00, 6'h08, 1'b0, 2, 2'b10, "jr"};
        tbl[18] = '{6'h33, 6'h00, 1'b0, 2, 2'b00, "unknown_op"};
        tbl[19] = '{6'h00, 6'h3f, 1'b0, 2, 2'b00, "unknown_func"};

        opPool = '{6'h00, 6'h00, 6'h08, 6'h0d, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h33};
        fnPool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08, 6'h17};

        RST = 1'b1; op = 6'h00; func = 6'h00; zero = 1'b0;
        #1 check("reset_async", 0, sample(), resetVec());
        @(posedge CLK); #1;
        check("reset_held", 0, sample(), resetVec());
        RST = 1'b0;

        foreach (tbl[i]) begin
            runInstr(tbl[i].op, tbl[i].func, tbl[i].z, tbl[i].name, cyc, pc);
            checkVal({tbl[i].name, "_cycles"}, cyc, tbl[i].cycles);
            checkVal({tbl[i].name, "_pcsrc"}, int'(pc), int'(tbl[i].pcSrc));
            checkVal({tbl[i].name, "_back_in_if"}, int'(state), 0);
        end

        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            o = opPool[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) begin
                o = 6'($urandom);
                if (o == 6'h3f) o = 6'h33;
            end
            f = (o == 6'h00) ? fnPool[$urandom_range(0, 7)] : 6'($urandom);
            runInstr(o, f, 1'($urandom), "random", cyc, pc);
        end

        // Reset asserted in the MEM cycle of sw must abort before the store.
        op = 6'h2b; func = 6'h00; zero = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            check("sw_pre_reset", s, sample(), model(6'h2b, 6'h00, 1'b0, s));
            if (s < 3) begin
                @(posedge CLK); #1;
            end
        end
        #2 RST = 1'b1;
        #1;
        a = sample();
        check("reset_mid_mem", 0, a, resetVec());
        checkVal("reset_mid_mem_mwr", int'(a.mWr), 0);
        @(posedge CLK); #1;
        check("reset_mid_mem_held", 0, sample(), resetVec());
        RST = 1'b0;
        runInstr(6'h08, 6'h00, 1'b0, "addi_after_reset", cyc, pc);
        checkVal("addi_after_reset_cycles", cyc, 4);

        op = 6'h3f; func = 6'h00; zero = 1'b0;
        #1;
        for (int s = 0; s < 22; s++) begin
            a = sample();
            check("halt", s, a, model(6'h3f, 6'h00, 1'b0, s));
            if (s >= 2) checkVal("halt_flag", int'(a.halted), 1);
            @(posedge CLK); #1;
            zero = ~zero;
        end
        RST = 1'b1;
        #1 check("reset_from_halt", 0, sample(), resetVec());
        @(posedge CLK); #1;
        RST = 1'b0;
        runInstr(6'h23, 6'h00, 1'b0, "lw_after_halt", cyc, pc);
        checkVal("lw_after_halt_cycles", cyc, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
